// File: rtl/can_stuff_pkg.sv
// Shared constants for the CAN receive-path de-stuffer.
package can_stuff_pkg;
    localparam int   STUFF_LIMIT = 5;
    localparam int   CNT_W       = 3;
    localparam logic RECESSIVE   = 1'b1;
    localparam logic DOMINANT    = 1'b0;
endpackage

// File: rtl/can_stuff_block_sp_edge.sv
// SP rising-edge detector: turns a level sample-point indication into a
// single-cycle event. Used only when SP_EDGE_DETECT_EN is defined.
module sp_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic SP,
    output logic sp_event
);
    logic r_sp_q;

    // Remember the previous SP level so a long high phase yields one event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_sp_q <= 1'b0;
        else        r_sp_q <= SP;
    end

    assign sp_event = SP & ~r_sp_q;
endmodule

// File: rtl/can_stuff_block.sv
// CAN receive-path bit de-stuffer. Drops the bit following five equal
// consecutive bits while F_STF is high; forwards every other sample as a
// one-cycle strobe plus bit value.
// Build option SP_EDGE_DETECT_EN: defined -> SP is a level and an edge
// detector creates the sample event; undefined -> SP is already a
// one-clock strobe and is used directly.
module can_stuff_block
    import can_stuff_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic RX,
    input  logic SP,
    input  logic F_STF,
    output logic sp_decision,
    output logic saida
);
    logic             w_event;
    logic             w_stuff;
    logic             w_same;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last;
    logic             r_sp_decision;
    logic             r_saida;

`ifdef SP_EDGE_DETECT_EN
    sp_edge_detect u_sp_edge (
        .clk      (clk),
        .reset    (reset),
        .SP       (SP),
        .sp_event (w_event)
    );
`else
    assign w_event = SP;
`endif

    // A stuff bit is the sample that follows a completed run of five.
    assign w_stuff = F_STF && (r_cnt == CNT_W'(STUFF_LIMIT));
    // Run continues only if a run is active and the level repeats.
    assign w_same  = (r_cnt != '0) && (RX == r_last);

    // Run tracking and de-stuffed output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sp_decision <= 1'b0;
            r_saida       <= RECESSIVE;
            r_cnt         <= '0;
            r_last        <= RECESSIVE;
        end else begin
            r_sp_decision <= 1'b0;
            if (w_event) begin
                r_last <= RX;
                if (w_stuff) begin
                    // Stuff bit (or stuff error): discarded, starts a new run.
                    r_cnt <= CNT_W'(1);
                end else begin
                    r_saida       <= RX;
                    r_sp_decision <= 1'b1;
                    if (!F_STF)     r_cnt <= '0;
                    else if (w_same) r_cnt <= r_cnt + CNT_W'(1);
                    else            r_cnt <= CNT_W'(1);
                end
            end
        end
    end

    assign sp_decision = r_sp_decision;
    assign saida       = r_saida;
endmodule

// File: tb/tb_can_stuff_block.sv
// Directed bench for can_stuff_block. SP is driven as one-clock pulses so
// the stimulus is valid with or without SP_EDGE_DETECT_EN; the level-SP
// scenario adapts its expectation to the build option.
module tb_can_stuff_block;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic RX = 1'b1;
    logic SP = 1'b0;
    logic F_STF = 1'b0;
    logic sp_decision;
    logic saida;

    int n_checks = 0;
    int n_fail   = 0;

    can_stuff_block dut (
        .clk         (clk),
        .reset       (reset),
        .RX          (RX),
        .SP          (SP),
        .F_STF       (F_STF),
        .sp_decision (sp_decision),
        .saida       (saida)
    );

    always #5 clk = ~clk;

    // One sample pulse; returns outputs one clock after the event and the
    // strobe on the following cycle (must be low).
    task automatic pulse(input logic rx, input logic f,
                         output logic st, output logic sd, output logic st2);
        @(negedge clk);
        RX = rx; F_STF = f; SP = 1'b1;
        @(posedge clk); #1;
        st = sp_decision; sd = saida;
        @(negedge clk);
        SP = 1'b0;
        @(posedge clk); #1;
        st2 = sp_decision;
    endtask

    task automatic test_reset();
        logic st, sd, st2;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            SP = ~SP; RX = 1'b0;
            @(posedge clk); #1;
            n_checks++;
            if (sp_decision !== 1'b0 || saida !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_hold cyc %0d: sp_decision=%b saida=%b, want 0/1", i, sp_decision, saida);
            end
        end
        @(negedge clk);
        SP = 1'b0; reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            pulse(1'b0, 1'b0, st, sd, st2);
            n_checks++;
            if (st !== 1'b1 || sd !== 1'b0 || st2 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release %0d: strobe=%b saida=%b next=%b, want 1/0/0", i, st, sd, st2);
            end
            @(posedge clk);
        end
    endtask

    task automatic test_stuff_zeros();
        logic st, sd, st2;
        logic rx[8], es[8], ed[8];
        rx = '{1, 0,0,0,0,0, 1, 0};
        es = '{1, 1,1,1,1,1, 0, 1};
        ed = '{1, 0,0,0,0,0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            pulse(rx[i], (i != 0), st, sd, st2);
            n_checks++;
            if (st !== es[i] || sd !== ed[i] || st2 !== 1'b0) begin
                n_fail++;
                $display("FAIL stuff_zeros bit %0d: strobe=%b saida=%b next=%b, want %b/%b/0", i, st, sd, st2, es[i], ed[i]);
            end
        end
    endtask

    task automatic test_stuff_ones();
        logic st, sd, st2;
        logic rx[12], es[12], ed[12];
        // bit 6 (stuff 0) starts a run, so bit 11 is the next stuff bit
        rx = '{0, 1,1,1,1,1, 0, 0,0,0,0, 1};
        es = '{1, 1,1,1,1,1, 0, 1,1,1,1, 0};
        ed = '{0, 1,1,1,1,1, 1, 0,0,0,0, 0};
        for (int i = 0; i < 12; i++) begin
            pulse(rx[i], (i != 0), st, sd, st2);
            n_checks++;
            if (st !== es[i] || sd !== ed[i] || st2 !== 1'b0) begin
                n_fail++;
                $display("FAIL stuff_ones bit %0d: strobe=%b saida=%b next=%b, want %b/%b/0", i, st, sd, st2, es[i], ed[i]);
            end
        end
    endtask

    task automatic test_stuff_error();
        logic st, sd, st2;
        logic es[12];
        // six zeros: sixth dropped, run restarts at 1 so eleventh dropped
        es = '{1, 1,1,1,1,1, 0, 1,1,1,1, 0};
        for (int i = 0; i < 12; i++) begin
            pulse((i == 0) ? 1'b1 : 1'b0, (i != 0), st, sd, st2);
            n_checks++;
            if (st !== es[i] || sd !== ((i == 0) ? 1'b1 : 1'b0) || st2 !== 1'b0) begin
                n_fail++;
                $display("FAIL stuff_error bit %0d: strobe=%b saida=%b next=%b, want %b", i, st, sd, st2, es[i]);
            end
        end
    endtask

    task automatic test_no_stuff_region();
        logic st, sd, st2;
        for (int i = 0; i < 14; i++) begin
            pulse(1'b1, (i >= 8), st, sd, st2);
            n_checks++;
            if (st !== ((i == 13) ? 1'b0 : 1'b1) || sd !== 1'b1 || st2 !== 1'b0) begin
                n_fail++;
                $display("FAIL no_stuff_region bit %0d: strobe=%b saida=%b next=%b", i, st, sd, st2);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic st, sd, st2;
        pulse(1'b1, 1'b0, st, sd, st2);
        for (int i = 0; i < 4; i++) pulse(1'b0, 1'b1, st, sd, st2);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (sp_decision !== 1'b0 || saida !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_clear: sp_decision=%b saida=%b, want 0/1", sp_decision, saida);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pulse(1'b0, 1'b1, st, sd, st2);
            n_checks++;
            if (st !== ((i == 5) ? 1'b0 : 1'b1) || sd !== 1'b0 || st2 !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_reset_run bit %0d: strobe=%b saida=%b next=%b", i, st, sd, st2);
            end
        end
    endtask

    task automatic test_sp_level();
        int strobes;
        strobes = 0;
        @(negedge clk);
        RX = 1'b0; F_STF = 1'b0; SP = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (sp_decision === 1'b1) strobes++;
        end
        @(negedge clk);
        SP = 1'b0;
        @(posedge clk); #1;
        if (sp_decision === 1'b1) strobes++;
        n_checks++;
`ifdef SP_EDGE_DETECT_EN
        if (strobes != 1) begin
`else
        if (strobes != 4) begin
`endif
            n_fail++;
            $display("FAIL sp_level: strobes=%0d for SP held 4 clocks", strobes);
        end
    endtask

    initial begin
        test_reset();
        test_stuff_zeros();
        test_stuff_ones();
        test_stuff_error();
        test_no_stuff_region();
        test_reset_mid_run();
        test_sp_level();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
